// File: rtl/cos_range_reducer_if.sv
// Handshake/bus bundle between the cosine range reducer and its neighbours.
// master: requester (drives start/angle_in, observes status and result).
// slave : the reducer (observes start/angle_in, drives busy/done/angle_out/negate).
//   start     request strobe, sampled only while the reducer is idle
//   angle_in  signed Q(ANGLE_W-24).23 angle in radians, sampled with start
//   busy      high while an operation is in flight
//   done      result-valid strobe (held level when built with DONE_HOLD_EN)
//   angle_out reduced angle in [0, pi/2], unsigned Q1.23
//   negate    downstream cosine result must be negated
interface cos_range_reducer_if #(
  parameter int unsigned ANGLE_W = 32,
  parameter int unsigned OUT_W   = 24
) ();
  logic               start;
  logic [ANGLE_W-1:0] angle_in;
  logic               busy;
  logic               done;
  logic [OUT_W-1:0]   angle_out;
  logic               negate;

  modport master (
    output start, angle_in,
    input  busy, done, angle_out, negate
  );

  modport slave (
    input  start, angle_in,
    output busy, done, angle_out, negate
  );
endinterface

// File: rtl/cos_range_reducer.sv
// Cosine range reducer: folds an arbitrary signed Q8.23 angle into [0, pi/2]
// and flags whether the cosine of the folded angle must be negated, using
// cos(x) = cos(-x) = -cos(pi - x).
// Ports:
//   clock  system clock
//   reset  synchronous, active-high; aborts any operation in flight
//   bus    cos_range_reducer_if.slave (start, angle_in, busy, done,
//          angle_out, negate)
// Build option: DONE_HOLD_EN keeps done high from the result until the next
// accepted start (or reset); otherwise done is a single-cycle pulse.
module cos_range_reducer #(
  parameter int unsigned ANGLE_W      = 32,
  parameter int unsigned OUT_W        = 24,
  parameter int unsigned FXP_SHIFT    = 23,
  parameter int unsigned REDUCE_STEPS = 6,
  parameter int unsigned TWO_PI       = 52707179,
  parameter int unsigned PI           = 26353589,
  parameter int unsigned HALF_PI      = 13176795
) (
  input  logic               clock,
  input  logic               reset,
  cos_range_reducer_if.slave bus
);

  localparam int unsigned CMP_W = ANGLE_W + REDUCE_STEPS;
  localparam int unsigned K_W   = (REDUCE_STEPS > 1) ? $clog2(REDUCE_STEPS) : 1;

  // Elaboration-time sanity checks on the parameter set.
  if (OUT_W != FXP_SHIFT + 1) begin : g_bad_out_w
    $error("cos_range_reducer: OUT_W must be FXP_SHIFT+1 (unsigned Q1.x)");
  end
  if ((64'(TWO_PI) << REDUCE_STEPS) <= (64'd1 << (ANGLE_W - 1))) begin : g_bad_steps
    $error("cos_range_reducer: REDUCE_STEPS too small to cover the input range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS,
    S_REDUCE,
    S_FOLD_PI,
    S_FOLD_HALF
  } state_t;

  state_t             state_q;
  logic [ANGLE_W-1:0] angle_q;
  logic [ANGLE_W-1:0] mag_q;
  logic [K_W-1:0]     k_q;
  logic               busy_q;
  logic               done_q;
  logic [OUT_W-1:0]   angle_out_q;
  logic               negate_q;

  // One shift-subtract step: compare at CMP_W bits so TWO_PI<<k never wraps.
  logic [CMP_W-1:0]   mag_ext_d;
  logic [CMP_W-1:0]   two_pi_shift_d;
  logic               step_ge_d;
  logic [ANGLE_W-1:0] step_sub_d;

  always_comb begin
    mag_ext_d      = CMP_W'(mag_q);
    two_pi_shift_d = CMP_W'(TWO_PI) << k_q;
    step_ge_d      = (mag_ext_d >= two_pi_shift_d);
    step_sub_d     = ANGLE_W'(mag_ext_d - two_pi_shift_d);
  end

  // Sequencer and result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      angle_q     <= '0;
      mag_q       <= '0;
      k_q         <= K_W'(REDUCE_STEPS - 1);
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      angle_out_q <= '0;
      negate_q    <= 1'b0;
    end else begin
`ifdef DONE_HOLD_EN
      // done is a level here; it is cleared only when the next start is taken.
`else
      done_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            angle_q <= bus.angle_in;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= S_ABS;
          end
        end

        S_ABS: begin
          // Two's-complement magnitude; the most negative input maps to
          // 2^(ANGLE_W-1), which still fits in ANGLE_W unsigned bits.
          mag_q   <= angle_q[ANGLE_W-1] ? (~angle_q + ANGLE_W'(1)) : angle_q;
          k_q     <= K_W'(REDUCE_STEPS - 1);
          state_q <= S_REDUCE;
        end

        S_REDUCE: begin
          if (step_ge_d) begin
            mag_q <= step_sub_d;
          end
          if (k_q == '0) begin
            state_q <= S_FOLD_PI;
          end else begin
            k_q <= k_q - K_W'(1);
          end
        end

        S_FOLD_PI: begin
          // Mirror (pi, 2pi) onto (0, pi); exactly pi stays put.
          if (mag_q > ANGLE_W'(PI)) begin
            mag_q <= ANGLE_W'(TWO_PI) - mag_q;
          end
          state_q <= S_FOLD_HALF;
        end

        S_FOLD_HALF: begin
          // Mirror (pi/2, pi] onto [0, pi/2) and flag the sign flip.
          if (mag_q > ANGLE_W'(HALF_PI)) begin
            angle_out_q <= OUT_W'(ANGLE_W'(PI) - mag_q);
            negate_q    <= 1'b1;
          end else begin
            angle_out_q <= OUT_W'(mag_q);
            negate_q    <= 1'b0;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.angle_out = angle_out_q;
  assign bus.negate    = negate_q;

endmodule

// File: doc/cos_range_reducer.md
Name: cos_range_reducer

Overview:
- Upstream stage of the Q1.23 cosine Taylor core.
- Takes an arbitrary signed fixed-point angle in radians and reduces it into [0, pi/2].
- Produces the 24-bit unsigned Q1.23 angle that drives the core's angle input.
- Produces a negate flag that the output stage applies to the core's result, using cos(x) = cos(-x) = -cos(pi-x).

Parameters:
- ANGLE_W, 32: input width; input format is signed Q(ANGLE_W-24).23, default Q8.23.
- OUT_W, 24: output width, unsigned Q1.23.
- FXP_SHIFT, 23: number of fraction bits, shared by input and output.
- REDUCE_STEPS, 6: shift-subtract iterations. Must satisfy 2pi*2^REDUCE_STEPS > 2^(ANGLE_W-1).
- TWO_PI, 52707179: 2pi in Q.23.
- PI, 26353589: pi in Q.23.
- HALF_PI, 13176795: pi/2 in Q.23.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- angle_in  in  ANGLE_W  signed Q8.23 angle in radians; sampled with start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  result valid strobe
- angle_out  out  OUT_W  reduced angle in [0, HALF_PI], Q1.23
- negate  out  1  1 = downstream result must be negated

Behaviour:
- Reset: synchronous, active-high; clock is clock. Outputs go to busy=0, done=0, angle_out=0, negate=0. State goes to IDLE and internal registers clear.
- Reset asserted mid-operation aborts the computation. No done is produced.
- States: IDLE -> ABS -> REDUCE (REDUCE_STEPS cycles, counter k from REDUCE_STEPS-1 down to 0) -> FOLD_PI -> FOLD_HALF -> IDLE.
- IDLE:
  - start=1 latches angle_in and moves to ABS. busy is 1 from the next cycle.
  - start while busy=1 is ignored; no queueing.
- ABS:
  - mag = |angle_in| as ANGLE_W-bit unsigned.
  - -2^(ANGLE_W-1) yields 2^(ANGLE_W-1) with no overflow.
  - Sign is discarded because cosine is even.
- REDUCE, per cycle: if mag >= (TWO_PI << k), then mag -= TWO_PI << k.
  - Compare width is ANGLE_W+REDUCE_STEPS bits, so there is no overflow.
  - After the final step, mag is in [0, TWO_PI).
- FOLD_PI: if mag > PI, then mag = TWO_PI - mag. Result is in [0, PI]. Exactly PI is left unchanged.
- FOLD_HALF:
  - If mag > HALF_PI: angle_out <= PI - mag, negate <= 1.
  - Otherwise: angle_out <= mag[OUT_W-1:0], negate <= 0.
  - In the same cycle: done <= 1, busy <= 0, return to IDLE.
- Latency: done rises 10 clock edges after the edge that samples start, counting that edge as 1. In general this is REDUCE_STEPS+4.
- done is a one-cycle pulse (default build).
- angle_out and negate stay stable until the next FOLD_HALF or reset.
- start high in the cycle done is high is accepted, so back-to-back operation is allowed.
- Boundary results:
  - mag exactly PI gives angle_out=0, negate=1 (cos = -1).
  - mag exactly HALF_PI gives angle_out=HALF_PI, negate=0.
- All arithmetic is unsigned after ABS. No rounding; results are exact integer Q.23.

Optional Feature:
- Macro: DONE_HOLD_EN.
- When defined:
  - done stays high from FOLD_HALF until the next start is accepted, or until reset.
  - This lets a level-sensitive downstream start input be driven directly.
- When undefined: done is a single-cycle pulse.
- All other behaviour and latency are identical in both builds.

Test Plan:
- angle_in=0, start pulse -> done at edge 10; angle_out=0, negate=0.
- angle_in=8784530 (pi/3) -> angle_out=8784530, negate=0. Then angle_in=17569060 (2pi/3) -> angle_out=8784529, negate=1.
- angle_in=-33554432 (-4.0) -> angle_out=7200842, negate=1. Then angle_in=83886080 (10.0) -> angle_out=4825311, negate=1.
- angle_in=-2147483648 (-256.0, most negative) -> angle_out=12842898, negate=1. angle_in=26353589 (pi) -> angle_out=0, negate=1.
- Hold start high across a whole operation with a new angle_in mid-operation -> first result is unaffected, second operation starts the cycle done is seen. Assert reset at REDUCE step 3 -> no done; outputs 0; next start completes normally.
- With DONE_HOLD_EN: done stays high for 5 idle cycles, then drops the cycle after the next start is accepted. Without the macro: done is high for exactly 1 cycle.
